// File: rtl/comparador_serial_id.sv
// Bit-serial MSB-first magnitude comparator: one operand bit pair per clock through
// the (m,n) -> (M,N) comparison cell, with a start/busy/done handshake.
module comparador_serial_id #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1,
  parameter int unsigned CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic [CW-1:0]    cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             m_q, m_d;
  logic             n_q, n_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  logic             a_bit_c, b_bit_c;
  logic             m_nxt_c, n_nxt_c;
  logic [CW-1:0]    count_inc_c;
  logic             last_c;

  // Comparison cell: (1,1) equal so far, (1,0) A>B, (0,1) A<B.
  assign a_bit_c     = a_sh_q[WIDTH-1];
  assign b_bit_c     = b_sh_q[WIDTH-1];
  assign m_nxt_c     = ~n_q | (m_q & (a_bit_c | ~b_bit_c));
  assign n_nxt_c     = ~m_q | (n_q & (~a_bit_c | b_bit_c));
  assign count_inc_c = count_q + CW'(1);
  assign last_c      = (count_inc_c == CW'(WIDTH)) ||
                       (EARLY_EXIT && !(m_nxt_c && n_nxt_c));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    m_d      = m_q;
    n_d      = n_q;
    count_d  = count_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    cycles_d = cycles_q;

    unique case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_RUN: begin
        m_d     = m_nxt_c;
        n_d     = n_nxt_c;
        a_sh_d  = a_sh_q << 1;
        b_sh_d  = b_sh_q << 1;
        count_d = count_inc_c;
        if (last_c) begin
          state_d  = S_DONE;
          gt_d     = m_nxt_c & ~n_nxt_c;
          lt_d     = ~m_nxt_c & n_nxt_c;
          eq_d     = m_nxt_c & n_nxt_c;
          cycles_d = count_inc_c;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Start is honoured from IDLE and DONE only; results stay untouched on load.
    if (start && (state_q != S_RUN)) begin
      state_d = S_RUN;
      a_sh_d  = a_in;
      b_sh_d  = b_in;
      m_d     = 1'b1;
      n_d     = 1'b1;
      count_d = '0;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      m_q      <= 1'b1;
      n_q      <= 1'b1;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      m_q      <= m_d;
      n_q      <= n_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      cycles_q <= cycles_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;
  assign a_eq_b = eq_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_comparador_serial_id.sv
// Bench for comparador_serial_id: four instances (WIDTH 8/3, EARLY_EXIT 0/1) checked
// through per-instance scoreboards of expected flags, cycles and start-to-done latency.
module tb_comparador_serial_id;

  typedef struct {
    logic [2:0] flags;      // {gt, lt, eq}
    int         cyc;
    int         start_edge;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] flags;
    int         c0;
    int         c1;
  } vec_t;

  logic       clk, reset;
  logic       start8, start3;
  logic [7:0] a8, b8;
  logic [2:0] a3, b3;

  logic       busy_8e0, done_8e0, gt_8e0, lt_8e0, eq_8e0;
  logic       busy_8e1, done_8e1, gt_8e1, lt_8e1, eq_8e1;
  logic       busy_3e0, done_3e0, gt_3e0, lt_3e0, eq_3e0;
  logic       busy_3e1, done_3e1, gt_3e1, lt_3e1, eq_3e1;
  logic [3:0] cyc_8e0, cyc_8e1;
  logic [1:0] cyc_3e0, cyc_3e1;

  exp_t q8e0[$], q8e1[$], q3e0[$], q3e1[$];
  exp_t e8e0, e8e1, e3e0, e3e1;

  int         errors = 0;
  int         checks = 0;
  int         edge_cnt = 0;
  logic [2:0] prev_fl = 3'b000;

  comparador_serial_id #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_8e0 (
    .clk(clk), .reset(reset), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy_8e0), .done(done_8e0), .a_gt_b(gt_8e0), .a_lt_b(lt_8e0),
    .a_eq_b(eq_8e0), .cycles(cyc_8e0));

  comparador_serial_id #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_8e1 (
    .clk(clk), .reset(reset), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy_8e1), .done(done_8e1), .a_gt_b(gt_8e1), .a_lt_b(lt_8e1),
    .a_eq_b(eq_8e1), .cycles(cyc_8e1));

  comparador_serial_id #(.WIDTH(3), .EARLY_EXIT(1'b0)) dut_3e0 (
    .clk(clk), .reset(reset), .start(start3), .a_in(a3), .b_in(b3),
    .busy(busy_3e0), .done(done_3e0), .a_gt_b(gt_3e0), .a_lt_b(lt_3e0),
    .a_eq_b(eq_3e0), .cycles(cyc_3e0));

  comparador_serial_id #(.WIDTH(3), .EARLY_EXIT(1'b1)) dut_3e1 (
    .clk(clk), .reset(reset), .start(start3), .a_in(a3), .b_in(b3),
    .busy(busy_3e1), .done(done_3e1), .a_gt_b(gt_3e1), .a_lt_b(lt_3e1),
    .a_eq_b(eq_3e1), .cycles(cyc_3e1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  task automatic score(input string name, input exp_t e, input logic [2:0] fl,
                       input logic [31:0] cy);
    chk({name, " flags"}, 32'(fl), 32'(e.flags));
    chk({name, " cycles"}, cy, 32'(e.cyc));
    chk({name, " latency"}, 32'(edge_cnt - e.start_edge), 32'(e.cyc));
  endtask

  // Scoreboard monitors: each done pulse pops one expectation.
  always @(negedge clk) if (done_8e0 === 1'b1) begin
    if (q8e0.size() == 0) chk("8e0 spurious done", 32'(done_8e0), 32'd0);
    else begin e8e0 = q8e0.pop_front(); score("8e0", e8e0, {gt_8e0, lt_8e0, eq_8e0}, 32'(cyc_8e0)); end
  end
  always @(negedge clk) if (done_8e1 === 1'b1) begin
    if (q8e1.size() == 0) chk("8e1 spurious done", 32'(done_8e1), 32'd0);
    else begin e8e1 = q8e1.pop_front(); score("8e1", e8e1, {gt_8e1, lt_8e1, eq_8e1}, 32'(cyc_8e1)); end
  end
  always @(negedge clk) if (done_3e0 === 1'b1) begin
    if (q3e0.size() == 0) chk("3e0 spurious done", 32'(done_3e0), 32'd0);
    else begin e3e0 = q3e0.pop_front(); score("3e0", e3e0, {gt_3e0, lt_3e0, eq_3e0}, 32'(cyc_3e0)); end
  end
  always @(negedge clk) if (done_3e1 === 1'b1) begin
    if (q3e1.size() == 0) chk("3e1 spurious done", 32'(done_3e1), 32'd0);
    else begin e3e1 = q3e1.pop_front(); score("3e1", e3e1, {gt_3e1, lt_3e1, eq_3e1}, 32'(cyc_3e1)); end
  end

  function automatic int pending();
    return q8e0.size() + q8e1.size() + q3e0.size() + q3e1.size();
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (pending() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pending() != 0) begin
      chk("timeout pending results", 32'(pending()), 32'd0);
      q8e0.delete(); q8e1.delete(); q3e0.delete(); q3e1.delete();
    end
  endtask

  // Expected bit pairs examined for a WIDTH=3 compare.
  function automatic int k3(input logic [2:0] a, input logic [2:0] b, input bit ee);
    if (!ee) return 3;
    for (int i = 2; i >= 0; i--) if (a[i] != b[i]) return 3 - i;
    return 3;
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] fl,
                      input int c0, input int c1);
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    q8e0.push_back('{fl, c0, edge_cnt + 1});
    q8e1.push_back('{fl, c1, edge_cnt + 1});
    @(negedge clk);
    start8 = 1'b0;
    chk("8e0 busy after start", 32'(busy_8e0), 32'd1);
    chk("8e0 flags held at start", 32'({gt_8e0, lt_8e0, eq_8e0}), 32'(prev_fl));
    prev_fl = fl;
    wait_idle(40);
  endtask

  task automatic run3(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] fl;
    fl = {a > b, a < b, a == b};
    @(negedge clk);
    a3 = a; b3 = b; start3 = 1'b1;
    q3e0.push_back('{fl, k3(a, b, 1'b0), edge_cnt + 1});
    q3e1.push_back('{fl, k3(a, b, 1'b1), edge_cnt + 1});
    @(negedge clk);
    start3 = 1'b0;
    wait_idle(20);
  endtask

  vec_t vecs[8];
  int   s;

  initial begin
    vecs[0] = '{8'h5A, 8'h5A, 3'b001, 8, 8};
    vecs[1] = '{8'h80, 8'h7F, 3'b100, 8, 1};
    vecs[2] = '{8'h12, 8'h13, 3'b010, 8, 8};
    vecs[3] = '{8'h13, 8'h12, 3'b100, 8, 8};
    vecs[4] = '{8'h00, 8'hFF, 3'b010, 8, 1};
    vecs[5] = '{8'h01, 8'h00, 3'b100, 8, 8};
    vecs[6] = '{8'hA5, 8'hB5, 3'b010, 8, 4};
    vecs[7] = '{8'h3C, 8'h34, 3'b100, 8, 5};

    reset = 1'b1; start8 = 1'b0; start3 = 1'b0;
    a8 = '0; b8 = '0; a3 = '0; b3 = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy_8e0), 32'd0);
    chk("reset done", 32'(done_8e0), 32'd0);
    chk("reset flags", 32'({gt_8e0, lt_8e0, eq_8e0, gt_3e1, lt_3e1, eq_3e1}), 32'd0);
    chk("reset cycles", 32'(cyc_8e1), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run8(vecs[i].a, vecs[i].b, vecs[i].flags, vecs[i].c0, vecs[i].c1);

    // Start pulsed mid-RUN with other operands must be ignored.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h5A; start8 = 1'b1;
    q8e0.push_back('{3'b001, 8, edge_cnt + 1});
    q8e1.push_back('{3'b001, 8, edge_cnt + 1});
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_idle(40);
    prev_fl = 3'b001;

    // Start held through DONE: second compare starts with no idle cycle.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h13; start8 = 1'b1;
    s = edge_cnt + 1;
    q8e0.push_back('{3'b010, 8, s});
    q8e1.push_back('{3'b010, 8, s});
    q8e0.push_back('{3'b100, 8, s + 9});
    q8e1.push_back('{3'b100, 5, s + 9});
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h34;
    repeat (8) @(negedge clk);
    @(negedge clk);
    chk("b2b busy in new run", 32'(busy_8e0), 32'd1);
    chk("b2b done cleared", 32'(done_8e0), 32'd0);
    start8 = 1'b0;
    wait_idle(40);
    prev_fl = 3'b100;

    // Asynchronous reset during RUN discards the compare without a done pulse.
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h5A; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset busy", 32'(busy_8e0), 32'd0);
    chk("async reset flags", 32'({gt_8e0, lt_8e0, eq_8e0, gt_8e1, lt_8e1, eq_8e1}), 32'd0);
    chk("async reset cycles", 32'({cyc_8e0, cyc_8e1}), 32'd0);
    chk("async reset done", 32'({done_8e0, done_8e1}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    prev_fl = 3'b000;
    repeat (2) @(negedge clk);
    run8(8'h01, 8'h00, 3'b100, 8, 8);

    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        run3(3'(a), 3'(b));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
